disp_row_scheduler: RTL and testbench

DISP_ROW_SCHEDULER -- requirements
Module: disp_row_scheduler

---
 rtl/disp_pkg.sv | 37 +++
 rtl/disp_timeout_ctr.sv | 36 +++
 rtl/disp_row_scheduler.sv | 175 +++++++++++++++++
 tb/tb_disp_row_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared types and helpers for the disparity row scheduler and
//               the disparity engine: FSM state encoding, width constants and
//               the legal-column-count derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

   // Row scheduler FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_EMIT   = 3'd4
   } state_t;

   // Default geometry shared with the engine
   localparam int DEF_IMG_W    = 128;
   localparam int DEF_WIN      = 15;
   localparam int DEF_MAX_DISP = 64;

   localparam int COL_BITS  = $clog2(DEF_IMG_W);
   localparam int DISP_BITS = $clog2(DEF_MAX_DISP);

   // Number of column positions where the full window and the full
   // disparity search both fit inside the row
   function automatic int ncol_calc(input int img_w, input int win, input int max_disp);
      return img_w - win - max_disp + 2;
   endfunction

   localparam int NCOL = ncol_calc(DEF_IMG_W, DEF_WIN, DEF_MAX_DISP);

endpackage
`default_nettype wire

// File: rtl/disp_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : disp_timeout_ctr
// Description : Watchdog counter for the engine wait phase. Counts enabled
//               cycles and flags the TIMEOUT-th consecutive one; clears as
//               soon as the enable drops.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_timeout_ctr #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic expired_o
);

   localparam int c_cnt_w = $clog2(TIMEOUT + 1);

   logic [c_cnt_w-1:0] cnt_q;

   // Count consecutive enabled cycles; hold once the limit is reached
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (!en_i) begin
         cnt_q <= '0;
      end else if (!expired_o) begin
         cnt_q <= cnt_q + c_cnt_w'(1);
      end
   end

   assign expired_o = en_i && (cnt_q == c_cnt_w'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/disp_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : disp_row_scheduler
// Description : Walks the legal column positions of one row band, clearing
//               and launching the disparity engine per column and handing
//               each result downstream over a valid/ready handshake.
//               Optional watchdog: define DISP_TIMEOUT_EN to add a WAIT
//               timeout that emits disparity 0 with out_err set.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_row_scheduler
   import disp_pkg::*;
#(
   parameter int IMG_W    = 128,
   parameter int WIN      = 15,
   parameter int MAX_DISP = 64,
   parameter int TIMEOUT  = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        row_start,
   output logic                        row_busy,
   output logic                        row_done,
   output logic                        eng_rst,
   output logic                        eng_ready,
   output logic [$clog2(IMG_W)-1:0]    eng_col,
   input  logic                        eng_done,
   input  logic [$clog2(MAX_DISP)-1:0] eng_disp,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(MAX_DISP)-1:0] out_disp,
   output logic [$clog2(IMG_W)-1:0]    out_col,
   output logic                        out_last
`ifdef DISP_TIMEOUT_EN
   ,
   output logic                        out_err
`endif
);

   localparam int c_col_w  = $clog2(IMG_W);
   localparam int c_disp_w = $clog2(MAX_DISP);
   localparam int c_ncol   = ncol_calc(IMG_W, WIN, MAX_DISP);
   localparam logic [c_col_w-1:0] c_last_col = c_col_w'(c_ncol - 1);

   if (c_ncol < 1) begin : g_bad_ncol
      $error("disp_row_scheduler: image too narrow for WIN and MAX_DISP");
   end

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("disp_row_scheduler: TIMEOUT must be at least 1");
   end

   state_t               state_q;
   logic [c_col_w-1:0]   col_q;
   logic                 row_busy_q;
   logic                 row_done_q;
   logic                 eng_rst_q;
   logic                 eng_ready_q;
   logic                 out_valid_q;
   logic [c_disp_w-1:0]  out_disp_q;
   logic [c_col_w-1:0]   out_col_q;
   logic                 out_last_q;

`ifdef DISP_TIMEOUT_EN
   logic out_err_q;
   logic wait_expired;

   disp_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .en_i      (state_q == ST_WAIT),
      .expired_o (wait_expired)
   );
`endif

   // Row sequencing FSM with all outputs registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         row_busy_q  <= 1'b0;
         row_done_q  <= 1'b0;
         eng_rst_q   <= 1'b1;
         eng_ready_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_disp_q  <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
`ifdef DISP_TIMEOUT_EN
         out_err_q   <= 1'b0;
`endif
      end else begin
         row_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               eng_rst_q   <= 1'b0;
               eng_ready_q <= 1'b0;
               // A start coinciding with the row_done pulse is dropped
               if (row_start && !row_done_q) begin
                  col_q      <= '0;
                  row_busy_q <= 1'b1;
                  eng_rst_q  <= 1'b1;
                  state_q    <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               eng_rst_q   <= 1'b0;
               eng_ready_q <= 1'b1;
               state_q     <= ST_LAUNCH;
            end
            ST_LAUNCH: begin
               eng_ready_q <= 1'b0;
               state_q     <= ST_WAIT;
            end
            ST_WAIT: begin
               if (eng_done) begin
                  out_valid_q <= 1'b1;
                  out_disp_q  <= eng_disp;
                  out_col_q   <= col_q;
                  out_last_q  <= (col_q == c_last_col);
`ifdef DISP_TIMEOUT_EN
                  out_err_q   <= 1'b0;
`endif
                  state_q     <= ST_EMIT;
               end
`ifdef DISP_TIMEOUT_EN
               else if (wait_expired) begin
                  out_valid_q <= 1'b1;
                  out_disp_q  <= '0;
                  out_col_q   <= col_q;
                  out_last_q  <= (col_q == c_last_col);
                  out_err_q   <= 1'b1;
                  state_q     <= ST_EMIT;
               end
`endif
            end
            ST_EMIT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (col_q == c_last_col) begin
                     row_done_q <= 1'b1;
                     row_busy_q <= 1'b0;
                     state_q    <= ST_IDLE;
                  end else begin
                     col_q     <= col_q + c_col_w'(1);
                     eng_rst_q <= 1'b1;
                     state_q   <= ST_CLEAR;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign row_busy  = row_busy_q;
   assign row_done  = row_done_q;
   assign eng_rst   = eng_rst_q;
   assign eng_ready = eng_ready_q;
   assign eng_col   = col_q;
   assign out_valid = out_valid_q;
   assign out_disp  = out_disp_q;
   assign out_col   = out_col_q;
   assign out_last  = out_last_q;
`ifdef DISP_TIMEOUT_EN
   assign out_err   = out_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_disp_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_row_scheduler
// Description : Directed self-checking bench for disp_row_scheduler with a
//               behavioural engine (result = col mod 64 five cycles after
//               launch) and a result monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_row_scheduler;

   localparam int c_ncol = 51;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       row_start = 1'b0;
   logic       row_busy, row_done, eng_rst, eng_ready;
   logic [6:0] eng_col;
   logic       eng_done = 1'b0;
   logic [5:0] eng_disp = 6'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [5:0] out_disp;
   logic [6:0] out_col;
   logic       out_last;
`ifdef DISP_TIMEOUT_EN
   logic       out_err;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   int rdy_mode  = 0;
   int rdy_phase = 0;
   int stuck_col = -1;

   always #5 clk = ~clk;

   disp_row_scheduler #(
      .IMG_W    (128),
      .WIN      (15),
      .MAX_DISP (64),
      .TIMEOUT  (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_start (row_start),
      .row_busy  (row_busy),
      .row_done  (row_done),
      .eng_rst   (eng_rst),
      .eng_ready (eng_ready),
      .eng_col   (eng_col),
      .eng_done  (eng_done),
      .eng_disp  (eng_disp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_disp  (out_disp),
      .out_col   (out_col),
      .out_last  (out_last)
`ifdef DISP_TIMEOUT_EN
      ,
      .out_err   (out_err)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Engine model: result ready five cycles after the launch strobe
   int eng_cnt = 0;
   bit eng_active = 1'b0;
   always @(negedge clk) begin
      if (eng_rst) begin
         eng_done   = 1'b0;
         eng_active = 1'b0;
      end else if (eng_ready) begin
         eng_cnt    = 5;
         eng_done   = 1'b0;
         eng_disp   = eng_col[5:0];
         eng_active = (int'(eng_col) != stuck_col);
      end else if (eng_active) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            eng_done   = 1'b1;
            eng_active = 1'b0;
         end
      end
   end

   // Downstream ready: always, or one cycle in three
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) begin
         out_ready = 1'b1;
      end else begin
         rdy_phase = (rdy_phase + 1) % 3;
         out_ready = (rdy_phase == 0);
      end
   end

   // Result monitor
   int exp_col = 0, n_res = 0, n_done = 0, n_erst = 0, n_erdy = 0, lat = 0;
   bit stalled = 1'b0, prev_valid = 1'b0;
   int st_col = 0, st_disp = 0;
   always @(negedge clk) begin
      if (rst) begin
         exp_col    = 0;
         stalled    = 1'b0;
         prev_valid = 1'b0;
         n_erst     = 0;
         n_erdy     = 0;
         lat        = 0;
      end else begin
         chk("rst_rdy_overlap", int'(eng_rst && eng_ready), 0);
         if (eng_rst && row_busy) n_erst++;
         if (eng_ready) begin
            n_erdy++;
            lat = 0;
         end else begin
            lat++;
         end
         if (row_done) n_done++;
         if (!out_valid) chk("last_without_valid", int'(out_last), 0);
         if (stalled) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_col", int'(out_col), st_col);
            chk("stall_disp", int'(out_disp), st_disp);
         end
         if (out_valid && !prev_valid)
            chk("latency", lat, (exp_col == stuck_col) ? 17 : 6);
         if (out_valid && out_ready) begin
            chk("col", int'(out_col), exp_col);
            chk("disp", int'(out_disp), (exp_col == stuck_col) ? 0 : exp_col % 64);
            chk("last", int'(out_last), int'(exp_col == c_ncol - 1));
            chk("eng_col_stable", int'(eng_col), exp_col);
            chk("erst_per_col", n_erst, 1);
            chk("erdy_per_col", n_erdy, 1);
`ifdef DISP_TIMEOUT_EN
            chk("err", int'(out_err), int'(exp_col == stuck_col));
`endif
            n_erst  = 0;
            n_erdy  = 0;
            n_res++;
            exp_col = (exp_col == c_ncol - 1) ? 0 : exp_col + 1;
         end
         stalled    = out_valid && !out_ready;
         st_col     = int'(out_col);
         st_disp    = int'(out_disp);
         prev_valid = out_valid;
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_row_busy"}, int'(row_busy), 0);
      chk({tag, "_row_done"}, int'(row_done), 0);
      chk({tag, "_eng_rst"}, int'(eng_rst), 1);
      chk({tag, "_eng_ready"}, int'(eng_ready), 0);
      chk({tag, "_eng_col"}, int'(eng_col), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_disp"}, int'(out_disp), 0);
      chk({tag, "_out_col"}, int'(out_col), 0);
      chk({tag, "_out_last"}, int'(out_last), 0);
`ifdef DISP_TIMEOUT_EN
      chk({tag, "_out_err"}, int'(out_err), 0);
`endif
   endtask

   task automatic start_row();
      row_start = 1'b1;
      @(posedge clk); #1;
      row_start = 1'b0;
      chk("start_busy", int'(row_busy), 1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (row_busy && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk("row_finish_in_budget", int'(row_busy), 0);
      @(posedge clk); #1;
   endtask

   initial begin : main
      int r0, d0, k;
      // Reset state
      #2 rst = 1'b1;
      #1 chk_reset_vals("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("eng_rst_held_after_release", int'(eng_rst), 1);
      @(posedge clk); #1;
      chk("eng_rst_drop", int'(eng_rst), 0);
      chk("idle_busy", int'(row_busy), 0);

      // Full row, ready always high
      r0 = n_res; d0 = n_done;
      start_row();
      wait_idle(3000);
      chk("row1_results", n_res - r0, c_ncol);
      chk("row1_row_done", n_done - d0, 1);
      chk("row1_done_single", int'(row_done), 0);

      // Throttled ready, stray starts mid-row and on row_done
      rdy_mode = 1;
      r0 = n_res; d0 = n_done;
      start_row();
      repeat (100) @(posedge clk);
      #1 row_start = 1'b1;
      @(posedge clk); #1;
      row_start = 1'b0;
      k = 0;
      while (!row_done && k < 5000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("row2_done_seen", int'(row_done), 1);
      chk("row2_results", n_res - r0, c_ncol);
      row_start = 1'b1;
      @(posedge clk); #1;
      chk("start_on_done_ignored", int'(row_busy), 0);
      @(posedge clk); #1;
      row_start = 1'b0;
      chk("start_after_done_taken", int'(row_busy), 1);
      rdy_mode = 0;
      wait_idle(3000);
      chk("row2_3_results", n_res - r0, 2 * c_ncol);
      chk("row2_3_row_done", n_done - d0, 2);

      // Reset while waiting on column 20
      start_row();
      k = 0;
      while (!(eng_ready && eng_col == 7'd20) && k < 1000) begin
         @(posedge clk); #1;
         k++;
      end
      @(posedge clk); #1;
      chk("mid_row_col", int'(eng_col), 20);
      rst = 1'b1;
      #1 chk_reset_vals("midrow");
      @(posedge clk); #1;
      chk_reset_vals("midrow_next");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrow_eng_rst_drop", int'(eng_rst), 0);
      r0 = n_res; d0 = n_done;
      start_row();
      chk("restart_col0", int'(eng_col), 0);
      wait_idle(3000);
      chk("row4_results", n_res - r0, c_ncol);
      chk("row4_row_done", n_done - d0, 1);

`ifdef DISP_TIMEOUT_EN
      // Engine never answers column 3
      stuck_col = 3;
      r0 = n_res;
      start_row();
      wait_idle(3000);
      chk("row5_results", n_res - r0, c_ncol);
      stuck_col = -1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
